// File: rtl/pcm_sample_buffer.sv
// Channel-selecting 24-bit PCM FIFO with a prime/stream release gate and a registered read port.
// Optional PCM_BUF_OVF_COUNT_EN adds a saturating dropped-sample counter on overflow_count_o.
module pcm_sample_buffer #(
    parameter logic        SELECT_LEFT = 1'b1,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned READY_LEVEL = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       sample_valid_i,
    input  logic [23:0]                left_sample_i,
    input  logic [23:0]                right_sample_i,
    output logic [23:0]                read_data_o,
    output logic                       read_valid_o,
    input  logic                       read_ready_i,
    output logic                       buffer_ready_o,
    output logic [$clog2(DEPTH):0]     fill_level_o,
    output logic                       overflow_o
`ifdef PCM_BUF_OVF_COUNT_EN
    ,
    output logic [15:0]                overflow_count_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {
        PRIME,
        STREAM
    } state_t;

    state_t        state_q, state_d;
    logic [23:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [23:0]   wr_data;
    logic          full, empty, accept, load, wr_en, drop;

    assign wr_data = SELECT_LEFT ? left_sample_i : right_sample_i;
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign accept  = read_valid_o && read_ready_i;
    // Full uses the registered count, so a same-cycle load never rescues a write.
    assign wr_en   = sample_valid_i && !full;
    assign drop    = sample_valid_i && full;
    assign load    = (state_q == STREAM) && !empty && (!read_valid_o || accept);

    always_comb begin
        state_d = state_q;
        case (state_q)
            PRIME:   if (count_q >= CW'(READY_LEVEL)) state_d = STREAM;
            STREAM:  if (empty && (!read_valid_o || accept)) state_d = PRIME;
            default: state_d = PRIME;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= PRIME;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            read_valid_o <= 1'b0;
            read_data_o  <= '0;
            overflow_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (load)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, load})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (load) begin
                read_valid_o <= 1'b1;
                read_data_o  <= mem[rd_ptr_q];
            end else if (accept) begin
                read_valid_o <= 1'b0;
            end
            if (drop) overflow_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en) mem[wr_ptr_q] <= wr_data;
    end

`ifdef PCM_BUF_OVF_COUNT_EN
    logic [15:0] ovf_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_cnt_q <= '0;
        end else if (drop && ovf_cnt_q != 16'hFFFF) begin
            ovf_cnt_q <= ovf_cnt_q + 1'b1;
        end
    end

    assign overflow_count_o = ovf_cnt_q;
`endif

    assign fill_level_o   = count_q;
    assign buffer_ready_o = (state_q == STREAM);

endmodule

// File: tb/tb_pcm_sample_buffer.sv
// Bench for pcm_sample_buffer: a queue-based model checked every cycle against a left-channel
// and a right-channel instance, plus directed literal expectations for each scenario.
module tb_pcm_sample_buffer;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned RL    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sv  = 1'b0;
    logic [23:0] ls  = '0;
    logic [23:0] rs  = '0;
    logic        rdy = 1'b0;

    logic [23:0] a_data, b_data;
    logic        a_valid, b_valid, a_br, b_br, a_ovf, b_ovf;
    logic [6:0]  a_fill, b_fill;
`ifdef PCM_BUF_OVF_COUNT_EN
    logic [15:0] a_ovc, b_ovc;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pcm_sample_buffer #(.SELECT_LEFT(1'b1), .DEPTH(DEPTH), .READY_LEVEL(RL)) dut_l (
        .clk_i(clk), .rst_i(rst), .sample_valid_i(sv),
        .left_sample_i(ls), .right_sample_i(rs),
        .read_data_o(a_data), .read_valid_o(a_valid), .read_ready_i(rdy),
        .buffer_ready_o(a_br), .fill_level_o(a_fill), .overflow_o(a_ovf)
`ifdef PCM_BUF_OVF_COUNT_EN
        , .overflow_count_o(a_ovc)
`endif
    );

    pcm_sample_buffer #(.SELECT_LEFT(1'b0), .DEPTH(DEPTH), .READY_LEVEL(RL)) dut_r (
        .clk_i(clk), .rst_i(rst), .sample_valid_i(sv),
        .left_sample_i(ls), .right_sample_i(rs),
        .read_data_o(b_data), .read_valid_o(b_valid), .read_ready_i(rdy),
        .buffer_ready_o(b_br), .fill_level_o(b_fill), .overflow_o(b_ovf)
`ifdef PCM_BUF_OVF_COUNT_EN
        , .overflow_count_o(b_ovc)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: stored samples as a queue of (left,right) pairs, plus the held output sample.
    logic [23:0] q_l[$];
    logic [23:0] q_r[$];
    bit          m_valid = 0, m_stream = 0, m_ovf = 0, armed = 0;
    logic [23:0] m_dl = '0, m_dr = '0;
    int          m_ovc = 0;

    always @(posedge clk) begin
        bit acc, full, ld, nxt;
        if (rst) begin
            q_l.delete(); q_r.delete();
            m_valid = 0; m_stream = 0; m_ovf = 0; m_ovc = 0;
            m_dl = '0; m_dr = '0;
            armed = 1;
        end else begin
            acc  = m_valid && rdy;
            full = (q_l.size() == DEPTH);
            ld   = m_stream && q_l.size() > 0 && (!m_valid || acc);
            if (!m_stream) nxt = (q_l.size() >= RL);
            else           nxt = !(q_l.size() == 0 && (!m_valid || acc));
            if (ld) begin
                m_dl = q_l.pop_front();
                m_dr = q_r.pop_front();
                m_valid = 1;
            end else if (acc) begin
                m_valid = 0;
            end
            if (sv) begin
                if (full) begin
                    m_ovf = 1;
                    if (m_ovc < 16'hFFFF) m_ovc++;
                end else begin
                    q_l.push_back(ls);
                    q_r.push_back(rs);
                end
            end
            m_stream = nxt;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("valid_l", a_valid, m_valid);
            check("valid_r", b_valid, m_valid);
            check("data_l", a_data, m_dl);
            check("data_r", b_data, m_dr);
            check("bready_l", a_br, m_stream);
            check("bready_r", b_br, m_stream);
            check("fill_l", a_fill, q_l.size());
            check("fill_r", b_fill, q_r.size());
            check("ovf_l", a_ovf, m_ovf);
            check("ovf_r", b_ovf, m_ovf);
`ifdef PCM_BUF_OVF_COUNT_EN
            check("ovc_l", a_ovc, m_ovc);
            check("ovc_r", b_ovc, m_ovc);
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write(input logic [23:0] l, input logic [23:0] r);
        sv = 1'b1; ls = l; rs = r;
        tick();
        sv = 1'b0;
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", a_valid, 0);
        check("rst_data", a_data, 0);
        check("rst_bready", a_br, 0);
        check("rst_fill", a_fill, 0);
        check("rst_ovf", a_ovf, 0);

        // Prime release
        for (int k = 1; k <= 16; k++) write(24'(k), 24'h800000 | 24'(k));
        check("prime_fill16", a_fill, 16);
        check("prime_br_N", a_br, 0);
        tick();
        check("prime_br_N1", a_br, 1);
        check("prime_rv_N1", a_valid, 0);
        tick();
        check("prime_rv_N2", a_valid, 1);
        check("prime_data", a_data, 1);
        check("chan_right", b_data, 24'h800001);
        check("prime_fill15", a_fill, 15);

        // Burst drain
        rdy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check("drain_valid", a_valid, 1);
            check("drain_data", a_data, i);
            tick();
        end
        check("drain_rv0", a_valid, 0);
        check("drain_prime", a_br, 0);
        rdy = 1'b0;

        // Overflow
        for (int k = 1; k <= 70; k++) write(24'(k), 24'h800000 | 24'(k));
        tick();
        check("ovf_fill64", a_fill, 64);
        check("ovf_flag", a_ovf, 1);
        check("ovf_head", a_data, 1);
`ifdef PCM_BUF_OVF_COUNT_EN
        check("ovf_count5", a_ovc, 5);
`endif
        rdy = 1'b1;
        for (int k = 1; k <= 65; k++) begin
            check("ovf_drain_valid", a_valid, 1);
            check("ovf_drain_data", a_data, k);
            tick();
        end
        check("ovf_drain_end", a_valid, 0);
        check("ovf_empty", a_fill, 0);
        check("ovf_sticky", a_ovf, 1);
        rdy = 1'b0;

        // Channel select and simultaneous write/load
        rst = 1'b1; tick(); rst = 1'b0;
        write(24'h7FFFFF, 24'h800001);
        for (int k = 2; k <= 16; k++) write(24'(100 + k), 24'h800000 | 24'(100 + k));
        tick(); tick();
        check("chan_left", a_data, 24'h7FFFFF);
        check("chan_right2", b_data, 24'h800001);
        rdy = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("sim_fill_pre", a_fill, 10);
        check("sim_head_pre", a_data, 106);
        sv = 1'b1; ls = 24'd200; rs = 24'h8000C8;
        tick();
        sv = 1'b0;
        check("sim_fill_keep", a_fill, 10);
        check("sim_order", a_data, 107);
        rdy = 1'b0;

        // Reset mid-stream
        for (int k = 1; k <= 10; k++) write(24'(300 + k), 24'(300 + k));
        check("mid_fill20", a_fill, 20);
        check("mid_valid", a_valid, 1);
        rst = 1'b1; tick();
        check("mrst_valid", a_valid, 0);
        check("mrst_data", a_data, 0);
        check("mrst_fill", a_fill, 0);
        check("mrst_bready", a_br, 0);
        check("mrst_ovf", a_ovf, 0);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) write(24'(400 + k), 24'(400 + k));
        check("rep_fill", a_fill, 16);
        tick(); tick();
        check("rep_valid", a_valid, 1);
        check("rep_data", a_data, 401);
        rdy = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        check("rep_drained", a_valid, 0);
        rdy = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
